// File: rtl/famicom_cpu_bus_master.sv
// Famicom 2A03-style CPU bus cycle generator: turns host requests into M2 / /ROMSEL / R/W / address / data
// bus cycles on the cartridge connector, with M2 free-running (or parked low) between transactions.
module famicom_cpu_bus_master #(
  parameter int unsigned LOW_CYCLES  = 3,
  parameter int unsigned HIGH_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter bit          FREE_RUN    = 1'b1,
  parameter logic [15:0] IDLE_ADDR   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in
);

  localparam int unsigned MAX_PH = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int unsigned CW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int unsigned HW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);

  typedef enum logic {PH_LOW, PH_HIGH} phase_t;

  phase_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          parked, boundary, enter_high;

  logic          busy_q, done_q, m2_q, romsel_q, rw_q, oe_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q, dout_q, rdata_q;
  logic [HW-1:0] hold_q;

  // Parked (FREE_RUN=0, nothing in flight) every clk is a cycle boundary, so a
  // request is taken on the next edge and the LOW phase restarts from count 0.
  always_comb begin
    parked     = !FREE_RUN && (state_q == PH_LOW) && (cnt_q == '0) && !busy_q;
    boundary   = parked || ((state_q == PH_HIGH) && (cnt_q == HIGH_LAST));
    enter_high = (state_q == PH_LOW) && (cnt_q == LOW_LAST);
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    case (state_q)
      PH_LOW: begin
        if (parked) begin
          cnt_d = '0;
        end else if (enter_high) begin
          state_d = PH_HIGH;
          cnt_d   = '0;
        end
      end
      PH_HIGH: begin
        if (boundary) begin
          state_d = PH_LOW;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = PH_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PH_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      m2_q     <= 1'b0;
      romsel_q <= 1'b1;
      rw_q     <= 1'b1;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      hold_q   <= '0;
    end else begin
      done_q <= 1'b0;

      // Write data lingers into LOW for the hold window, then releases the bus.
      if ((state_q == PH_LOW) && oe_q) begin
        if (hold_q == HW'(1)) oe_q <= 1'b0;
        else hold_q <= hold_q - 1'b1;
      end

      if (boundary) begin
        m2_q     <= 1'b0;
        romsel_q <= 1'b1;
        if (busy_q) begin
          done_q <= 1'b1;
          if (rw_q) rdata_q <= cpu_data_in;
        end
        if ((state_q == PH_HIGH) && oe_q) hold_q <= HOLD_INIT;
        if (req) begin
          busy_q  <= 1'b1;
          addr_q  <= req_addr;
          rw_q    <= ~req_we;
          wdata_q <= req_wdata;
        end else begin
          busy_q <= 1'b0;
          addr_q <= IDLE_ADDR;
          rw_q   <= 1'b1;
        end
      end else if (enter_high) begin
        m2_q     <= 1'b1;
        romsel_q <= ~addr_q[15];
        if (!rw_q) begin
          oe_q   <= 1'b1;
          dout_q <= wdata_q;
        end
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rdata        = rdata_q;
  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = rw_q;
  assign cpu_addr     = addr_q[14:0];
  assign cpu_data_out = dout_q;
  assign cpu_data_oe  = oe_q;

endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
// Bench for famicom_cpu_bus_master: a free-running instance and a parked (FREE_RUN=0) instance,
// with a small cartridge model and a queue of expected read/write bytes popped at each done.
module tb_famicom_cpu_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, p_req;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  cart_rd;

  logic        busy, done, m2, romsel, cpu_rw, cpu_data_oe;
  logic [7:0]  rdata, cpu_data_out, cpu_data_in;
  logic [14:0] cpu_addr;

  logic        p_busy, p_done, p_m2, p_romsel, p_cpu_rw, p_cpu_data_oe;
  logic [7:0]  p_rdata, p_cpu_data_out, p_cpu_data_in;
  logic [14:0] p_cpu_addr;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Cartridge drives its data only while M2 is high.
  assign cpu_data_in   = m2   ? cart_rd : 8'hEE;
  assign p_cpu_data_in = p_m2 ? 8'h5A   : 8'hEE;

  famicom_cpu_bus_master #(.LOW_CYCLES(3), .HIGH_CYCLES(3), .HOLD_CYCLES(1),
                           .FREE_RUN(1'b1), .IDLE_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata), .m2(m2),
    .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in));

  famicom_cpu_bus_master #(.LOW_CYCLES(3), .HIGH_CYCLES(3), .HOLD_CYCLES(1),
                           .FREE_RUN(1'b0), .IDLE_ADDR(16'h0000)) dut_p (
    .clk(clk), .rst(rst), .req(p_req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(p_busy), .done(p_done), .rdata(p_rdata), .m2(p_m2),
    .romsel(p_romsel), .cpu_rw(p_cpu_rw), .cpu_addr(p_cpu_addr),
    .cpu_data_out(p_cpu_data_out), .cpu_data_oe(p_cpu_data_oe), .cpu_data_in(p_cpu_data_in));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; p_req = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; cart_rd = 8'hA5;
    repeat (3) tick();
    checks++;
    if ({m2, romsel, cpu_rw, cpu_addr, cpu_data_oe, cpu_data_out, rdata, done, busy} !==
        {1'b0, 1'b1, 1'b1, 15'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_main got m2=%b romsel=%b rw=%b addr=%h oe=%b dout=%h rdata=%h done=%b busy=%b exp 0 1 1 0000 0 00 00 0 0",
               m2, romsel, cpu_rw, cpu_addr, cpu_data_oe, cpu_data_out, rdata, done, busy);
    end
    checks++;
    if ({p_m2, p_romsel, p_cpu_rw, p_cpu_addr, p_cpu_data_oe, p_cpu_data_out, p_rdata, p_done, p_busy} !==
        {1'b0, 1'b1, 1'b1, 15'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_parked got m2=%b romsel=%b rw=%b addr=%h oe=%b dout=%h rdata=%h done=%b busy=%b exp 0 1 1 0000 0 00 00 0 0",
               p_m2, p_romsel, p_cpu_rw, p_cpu_addr, p_cpu_data_oe, p_cpu_data_out, p_rdata, p_done, p_busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 1; i <= 24; i++) begin
      logic exp_m2;
      tick();
      exp_m2 = ((i % 6) >= 3);
      checks++;
      if ({m2, romsel, cpu_rw, cpu_addr, cpu_data_oe, done} !== {exp_m2, 1'b1, 1'b1, 15'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_clk%0d got m2=%b romsel=%b rw=%b addr=%h oe=%b done=%b exp m2=%b 1 1 0000 0 0",
                 i, m2, romsel, cpu_rw, cpu_addr, cpu_data_oe, done, exp_m2);
      end
    end
  endtask

  task automatic test_read();
    int n, highs, bad;
    logic [7:0] e;
    cart_rd = 8'hA5;
    exp_q.push_back(8'hA5);
    req_we = 1'b0; req_addr = 16'h8123; req = 1'b1;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    checks++;
    if (!busy || {cpu_addr, cpu_rw, m2} !== {15'h0123, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL read_accept got busy=%b addr=%h rw=%b m2=%b exp 1 0123 1 0", busy, cpu_addr, cpu_rw, m2);
    end
    req = 1'b0; req_addr = 16'hFFFF;
    n = 0; highs = 0; bad = 0;
    while (!done && n < 20) begin
      tick(); n++;
      if (!done) begin
        if (m2) highs++;
        if (cpu_addr !== 15'h0123 || cpu_rw !== 1'b1 || romsel !== ~m2 || cpu_data_oe !== 1'b0) bad++;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (n != 6 || !done) begin errors++; $display("FAIL read_latency got %0d clks done=%b exp 6 clks", n, done); end
    checks++;
    if (highs != 3) begin errors++; $display("FAIL read_m2_high got %0d exp 3", highs); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL read_bus_shape got %0d bad clks exp 0", bad); end
    checks++;
    if ({rdata, m2, busy} !== {e, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL read_done got rdata=%h m2=%b busy=%b exp %h 0 0", rdata, m2, busy, e);
    end
    tick();
    checks++;
    if ({rdata, done} !== {e, 1'b0}) begin
      errors++;
      $display("FAIL read_hold got rdata=%h done=%b exp %h 0", rdata, done, e);
    end
  endtask

  task automatic test_write();
    int n, oe_cnt, bad;
    logic [7:0] e;
    exp_q.push_back(8'h3C);
    req_we = 1'b1; req_addr = 16'h6000; req_wdata = 8'h3C; req = 1'b1;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    checks++;
    if (!busy || {cpu_addr, cpu_rw, cpu_data_oe} !== {15'h6000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL write_accept got busy=%b addr=%h rw=%b oe=%b exp 1 6000 0 0", busy, cpu_addr, cpu_rw, cpu_data_oe);
    end
    req = 1'b0; req_wdata = 8'h00;
    n = 0; oe_cnt = 0; bad = 0;
    while (!done && n < 20) begin
      tick(); n++;
      if (!done) begin
        if (cpu_data_oe && cpu_data_out === 8'h3C) oe_cnt++;
        if (romsel !== 1'b1 || cpu_rw !== 1'b0 || cpu_addr !== 15'h6000 || cpu_data_oe !== m2) bad++;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (n != 6 || !done) begin errors++; $display("FAIL write_latency got %0d clks done=%b exp 6", n, done); end
    checks++;
    if (oe_cnt != 3) begin errors++; $display("FAIL write_oe_high got %0d clks exp 3", oe_cnt); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL write_bus_shape got %0d bad clks exp 0", bad); end
    checks++;
    if ({cpu_data_oe, cpu_data_out, m2} !== {1'b1, e, 1'b0}) begin
      errors++;
      $display("FAIL write_hold got oe=%b data=%h m2=%b exp 1 %h 0", cpu_data_oe, cpu_data_out, m2, e);
    end
    tick();
    checks++;
    if (cpu_data_oe !== 1'b0) begin errors++; $display("FAIL write_release got oe=%b exp 0", cpu_data_oe); end
  endtask

  task automatic test_back_to_back();
    int n, rs_low, bad;
    logic [14:0] prev;
    logic [7:0] seen, e;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h01);
    req_we = 1'b1; req_addr = 16'h8000; req_wdata = 8'h80; req = 1'b1;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    req_addr = 16'hA001; req_wdata = 8'h01;
    prev = cpu_addr; seen = 8'h00; rs_low = 0; bad = 0; n = 0;
    while (!done && n < 20) begin
      tick(); n++;
      if (!done) begin
        if (m2 && romsel === 1'b0) rs_low++;
        if (m2 && cpu_data_oe) seen = cpu_data_out;
        if (m2 && cpu_addr !== prev) bad++;
      end
      prev = cpu_addr;
    end
    e = exp_q.pop_front();
    checks++;
    if (seen !== e) begin errors++; $display("FAIL b2b_first_data got %h exp %h", seen, e); end
    checks++;
    if ({done, busy, cpu_addr, cpu_rw} !== {1'b1, 1'b1, 15'h2001, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second_accept got done=%b busy=%b addr=%h rw=%b exp 1 1 2001 0", done, busy, cpu_addr, cpu_rw);
    end
    req = 1'b0;
    n = 0;
    while (!done || n == 0) begin
      if (n >= 20) break;
      tick(); n++;
      if (!done) begin
        if (m2 && romsel === 1'b0) rs_low++;
        if (m2 && cpu_data_oe) seen = cpu_data_out;
        if (m2 && cpu_addr !== prev) bad++;
      end
      prev = cpu_addr;
    end
    e = exp_q.pop_front();
    checks++;
    if (n != 6 || !done) begin errors++; $display("FAIL b2b_gap got %0d clks between dones exp 6", n); end
    checks++;
    if ({seen, busy} !== {e, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second_data got data=%h busy=%b exp %h 0", seen, busy, e);
    end
    checks++;
    if (rs_low != 6 || bad != 0) begin
      errors++;
      $display("FAIL b2b_romsel_addr got romsel_low=%0d addr_moves=%0d exp 6 0", rs_low, bad);
    end
  endtask

  task automatic test_parked();
    int n, t_high, bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (p_m2 !== 1'b0 || p_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL park_idle got %0d clks with m2 or busy high exp 0", bad); end
    exp_q.push_back(8'h5A);
    req_we = 1'b0; req_addr = 16'hC000; p_req = 1'b1;
    n = 0; t_high = 0; bad = 0;
    while (!p_done && n < 20) begin
      tick(); n++;
      if (p_m2 && t_high == 0) t_high = n;
      if (p_m2 && p_romsel !== 1'b0) bad++;
      if (n == 1) begin
        checks++;
        if ({p_busy, p_cpu_addr, p_m2} !== {1'b1, 15'h4000, 1'b0}) begin
          errors++;
          $display("FAIL park_accept got busy=%b addr=%h m2=%b exp 1 4000 0", p_busy, p_cpu_addr, p_m2);
        end
        p_req = 1'b0;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (t_high != 4) begin errors++; $display("FAIL park_m2_rise got clk %0d exp clk 4", t_high); end
    checks++;
    if (n != 7 || !p_done) begin errors++; $display("FAIL park_done got clk %0d exp clk 7", n); end
    checks++;
    if ({p_rdata, bad} !== {e, 32'd0}) begin
      errors++;
      $display("FAIL park_read got rdata=%h romsel_bad=%0d exp %h 0", p_rdata, bad, e);
    end
  endtask

  task automatic test_reset_mid();
    int n, dones;
    logic [7:0] e;
    req_we = 1'b1; req_addr = 16'h8000; req_wdata = 8'h55; req = 1'b1;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    req = 1'b0;
    n = 0;
    while (!m2 && n < 10) begin tick(); n++; end
    tick();
    checks++;
    if ({m2, cpu_data_oe, cpu_data_out, romsel} !== {1'b1, 1'b1, 8'h55, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_pre got m2=%b oe=%b data=%h romsel=%b exp 1 1 55 0", m2, cpu_data_oe, cpu_data_out, romsel);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m2, romsel, cpu_data_oe, busy, done, cpu_rw, cpu_addr} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0}) begin
      errors++;
      $display("FAIL rstmid_async got m2=%b romsel=%b oe=%b busy=%b done=%b rw=%b addr=%h exp 0 1 0 0 0 1 0000",
               m2, romsel, cpu_data_oe, busy, done, cpu_rw, cpu_addr);
    end
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL rstmid_no_done got %0d dones exp 0", dones); end
    cart_rd = 8'hC3;
    exp_q.push_back(8'hC3);
    req_we = 1'b0; req_addr = 16'h8123; req = 1'b1;
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    req = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    e = exp_q.pop_front();
    checks++;
    if ({done, rdata} !== {1'b1, e} || n != 6) begin
      errors++;
      $display("FAIL rstmid_read_after got done=%b rdata=%h clks=%0d exp 1 %h 6", done, rdata, n, e);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_read();
    test_write();
    test_back_to_back();
    test_parked();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d entries exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
